// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the pipeline hazard scoreboard.
// Holds the forwarding select encodings and the per-stage register tag layouts.
package hazard_scoreboard_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic             valid;
        logic             regw;
        logic             memread;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
    } ex_tag_t;

    typedef struct packed {
        logic             regw;
        logic             memread;
        logic [REG_W-1:0] rd;
    } mem_tag_t;

    typedef struct packed {
        logic             regw;
        logic [REG_W-1:0] rd;
    } wb_tag_t;

endpackage

// File: rtl/hazard_scoreboard_fwd_select.sv
// Prioritised forwarding select for one EX operand.
// The younger producer in MEM beats the older one in WB; x0 is never forwarded.
module hazard_scoreboard_fwd_select
    import hazard_scoreboard_pkg::*;
(
    input  logic             ex_valid_i,
    input  logic [REG_W-1:0] ex_rs_i,
    input  logic             mem_regw_i,
    input  logic             mem_load_i,
    input  logic [REG_W-1:0] mem_rd_i,
    input  logic             wb_regw_i,
    input  logic [REG_W-1:0] wb_rd_i,
    output logic [1:0]       fwd_o
);

    logic memHit;
    logic wbHit;

    // A load in MEM has no data yet; the load-use stall keeps its dependents out of EX.
    assign memHit = mem_regw_i && !mem_load_i && (mem_rd_i != '0) && (mem_rd_i == ex_rs_i);
    assign wbHit  = wb_regw_i && (wb_rd_i != '0) && (wb_rd_i == ex_rs_i);

    always_comb begin
        fwd_o = FWD_RF;
        if (ex_valid_i) begin
            if (memHit) begin
                fwd_o = FWD_MEM;
            end else if (wbHit) begin
                fwd_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard controller for the 5-stage pipeline: tracks EX/MEM/WB register tags and
// produces load-use stall, flush bubbles, memory freeze and EX forwarding selects.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int XLEN_REGS = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         id_valid,
    input  logic [$clog2(XLEN_REGS)-1:0] id_rs1,
    input  logic [$clog2(XLEN_REGS)-1:0] id_rs2,
    input  logic [$clog2(XLEN_REGS)-1:0] id_rd,
    input  logic                         id_regw,
    input  logic                         id_memread,
    input  logic                         flush,
    input  logic                         mem_busy,
    output logic                         stall_if_id,
    output logic                         bubble_id_ex,
    output logic                         freeze_all,
    output logic [1:0]                   forward_a,
    output logic [1:0]                   forward_b,
    output logic [CNT_W-1:0]             stall_count
);

    ex_tag_t          ex_q, ex_d;
    mem_tag_t         mem_q, mem_d;
    wb_tag_t          wb_q, wb_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             loadUse;

    assign loadUse = id_valid && ex_q.valid && ex_q.memread && (ex_q.rd != '0) &&
                     ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));

    assign freeze_all   = mem_busy;
    assign stall_if_id  = mem_busy || (loadUse && !flush);
    assign bubble_id_ex = !mem_busy && (flush || loadUse);
    assign stall_count  = stall_count_q;

    // A busy memory freezes everything, including a pending flush; otherwise tags
    // advance one stage and EX takes either a bubble or the ID instruction.
    always_comb begin
        ex_d          = ex_q;
        mem_d         = mem_q;
        wb_d          = wb_q;
        stall_count_d = stall_count_q;
        if (!mem_busy) begin
            mem_d.regw    = ex_q.regw;
            mem_d.memread = ex_q.memread;
            mem_d.rd      = ex_q.rd;
            wb_d.regw     = mem_q.regw;
            wb_d.rd       = mem_q.rd;
            if (flush || loadUse) begin
                ex_d = '0;
            end else begin
                ex_d.valid   = id_valid;
                ex_d.regw    = id_regw && id_valid;
                ex_d.memread = id_memread && id_valid;
                ex_d.rd      = id_rd;
                ex_d.rs1     = id_rs1;
                ex_d.rs2     = id_rs2;
            end
            if (loadUse && !flush && (stall_count_q != '1)) begin
                stall_count_d = stall_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            stall_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            wb_q          <= wb_d;
            stall_count_q <= stall_count_d;
        end
    end

    hazard_scoreboard_fwd_select u_fwd_a (
        .ex_valid_i (ex_q.valid),
        .ex_rs_i    (ex_q.rs1),
        .mem_regw_i (mem_q.regw),
        .mem_load_i (mem_q.memread),
        .mem_rd_i   (mem_q.rd),
        .wb_regw_i  (wb_q.regw),
        .wb_rd_i    (wb_q.rd),
        .fwd_o      (forward_a)
    );

    hazard_scoreboard_fwd_select u_fwd_b (
        .ex_valid_i (ex_q.valid),
        .ex_rs_i    (ex_q.rs2),
        .mem_regw_i (mem_q.regw),
        .mem_load_i (mem_q.memread),
        .mem_rd_i   (mem_q.rd),
        .wb_regw_i  (wb_q.regw),
        .wb_rd_i    (wb_q.rd),
        .fwd_o      (forward_b)
    );

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Sequential hazard controller for the 5-stage RISC-V pipeline.
- Keeps its own copy of the register tags for the instructions in EX, MEM and WB. From these it generates the load-use stall and bubble, branch flush bubbles, and full-pipe freeze for a busy data memory.
- Generates 2-bit forwarding selects for the EX-stage operand muxes, covering both EX/MEM and MEM/WB sources.
- Sits beside the pipeline registers. Its outputs replace ad-hoc stall/forward logic in the top level.

Parameters:
- CNT_W, 16, width of the saturating load-use stall counter.
- XLEN_REGS, 32, number of architectural registers. Register index width is log2 of this, 5 by default.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs1  input  5  ID-stage source register 1.
- id_rs2  input  5  ID-stage source register 2.
- id_rd  input  5  ID-stage destination register.
- id_regw  input  1  ID instruction writes the register file.
- id_memread  input  1  ID instruction is a load.
- flush  input  1  branch/jump taken, resolved in EX; kill the ID instruction.
- mem_busy  input  1  data memory not ready; freeze the whole pipe.
- stall_if_id  output  1  hold PC and IF/ID register.
- bubble_id_ex  output  1  load ID/EX with a NOP.
- freeze_all  output  1  hold every pipeline register (equals mem_busy).
- forward_a  output  2  EX operand A select: 00 regfile, 01 MEM/WB, 10 EX/MEM.
- forward_b  output  2  EX operand B select, same encoding.
- stall_count  output  CNT_W  number of load-use stall cycles, saturating.

Behaviour:
- Internal tag registers:
  - ex_tag = {valid, regw, memread, rd, rs1, rs2}
  - mem_tag = {regw, memread, rd}
  - wb_tag = {regw, rd}
- Reset, asynchronous: all tags cleared (valid=0, regw=0, memread=0, indices 0) and stall_count=0. All outputs are therefore 0 during and immediately after reset.
- load_use is combinational: id_valid & ex.valid & ex.memread & ex.rd!=0 & (ex.rd==id_rs1 | ex.rd==id_rs2).
  - Checking rs2 unconditionally is acceptable and conservative.
- Output equations, all combinational from the tags and current inputs:
  - freeze_all = mem_busy.
  - stall_if_id = mem_busy | (load_use & ~flush).
  - bubble_id_ex = ~mem_busy & (flush | load_use).
- Tag update on each rising edge, in priority order:
  1. mem_busy=1: all tags hold. flush is ignored; its source must hold it until mem_busy=0.
  2. flush=1: ex_tag <= bubble (all zero). flush beats load_use, because the killed instruction needs no stall.
  3. load_use=1: ex_tag <= bubble.
  4. Otherwise: ex_tag <= {id_valid, id_regw&id_valid, id_memread&id_valid, id_rd, id_rs1, id_rs2}.
  - In cases 2–4, mem_tag <= ex_tag fields and wb_tag <= mem_tag fields. A bubble in EX therefore propagates as regw=0.
- Forwarding, combinational from the tags. For operand A, checked in priority order:
  - 10 if mem.regw & mem.rd!=0 & mem.rd==ex.rs1.
  - else 01 if wb.regw & wb.rd!=0 & wb.rd==ex.rs1.
  - else 00.
  - Operand B is identical using ex.rs2.
  - ex.valid=0 forces 00.
  - A load in MEM never hits the 10 path for a dependent in EX; the load-use stall guarantees at least one bubble between them.
- x0 is never forwarded or stalled on.
- stall_count increments on every clock edge where load_use=1, flush=0 and mem_busy=0. It saturates at all-ones and does not wrap.
- Latency: stall and bubble are same-cycle (combinational). A load-use hazard costs exactly 1 stall cycle.
- Reset asserted mid-stall clears the tags immediately. The first ID instruction after reset never stalls.

Decomposition:
- Shared package:
  - forward select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - Register index width REG_W=5.
  - Tag struct typedefs for EX, MEM and WB.
- One natural sub-module: fwd_select. It is combinational, instantiated twice (operand A and operand B), and implements the prioritised 2-bit select from (ex_rs, mem tag, wb tag).

Test Plan:
- Reset release: rst_n low→high with id_valid=0 → all outputs 0, stall_count=0; first edge loads ex_tag.valid=0.
- Load-use: cycle 0 ID = lw x5; cycle 1 ID = add x6,x5,x1 → cycle 1 stall_if_id=1, bubble_id_ex=1, stall_count=1. Cycle 2: no stall. Cycle 3, add in EX: forward_a=01.
- Back-to-back ALU: add x3,.. followed by sub x4,x3,x3 → when sub is in EX, forward_a=forward_b=10. One cycle later, with the first instruction in WB and the second in MEM, no forward for the sub (already issued).
- Double hit priority: add x7; add x7; or x8,x7,x0 → when or is in EX, forward_a=10 (younger wins) and forward_b=00.
- Flush vs load-use: lw x5 in EX, ID = add x6,x5,x5, flush=1 → bubble_id_ex=1, stall_if_id=0, stall_count unchanged.
- Freeze: mem_busy=1 for 3 cycles mid-sequence with flush=1 → tags and forward selects held constant, bubble_id_ex=0, freeze_all=1. After release, the sequence resumes identically.
- Saturation: force CNT_W=2, generate 5 load-use stalls → stall_count stays 3.
